// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a raw asynchronous input and commits a new level only after
// STABLE_CYCLES consecutive matching samples, with registered rise/fall strobes and busy flag.
module input_debouncer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   input  logic enable,
   output logic level_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);
   // bit 1 is the committed level, bit 0 marks a stability check in progress
   localparam logic [1:0] IDLE_LOW   = 2'b00;
   localparam logic [1:0] CHECK_HIGH = 2'b01;
   localparam logic [1:0] IDLE_HIGH  = 2'b10;
   localparam logic [1:0] CHECK_LOW  = 2'b11;
   logic [SYNC_STAGES-1:0] sync;
   logic [1:0] state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic sync_q, target, match, done, commit;
   assign sync_q = sync[SYNC_STAGES-1];
   assign target = ~state[1];
   assign match  = sync_q == target;
   assign done   = state[0] ? cnt == CNT_W'(STABLE_CYCLES - 1) : STABLE_CYCLES == 1;
   assign commit = enable && match && done;
   assign level_out = state[1];
   assign busy      = state[0];
   always_comb begin
      state_n = !enable || !match ? {state[1], 1'b0} : done ? {~state[1], 1'b0} : {state[1], 1'b1};
      cnt_n   = !enable || !match || done ? '0 : cnt + 1'b1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync       <= '0;
         state      <= IDLE_LOW;
         cnt        <= '0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], raw_in};
         state      <= state_n;
         cnt        <= cnt_n;
         rise_pulse <= commit && target;
         fall_pulse <= commit && !target;
      end
   end
   logic unused_states;
   assign unused_states = ^{CHECK_HIGH, IDLE_HIGH, CHECK_LOW};
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: random and directed stimulus against a run-length reference model,
// with expected outputs queued per edge and compared by an independent monitor.
module tb_input_debouncer;
   localparam int SS = 2;
   localparam int ST = 16;
   logic clk = 0, reset = 1, raw_in = 0, enable = 1;
   logic level_out, rise_pulse, fall_pulse, busy;
   int checks = 0, errors = 0, edges = 0, rise_cnt = 0, fall_cnt = 0, lat;
   logic busy_seen = 0;
   logic [3:0] exp_q[$];
   logic pipe[SS];
   logic m_level;
   int run;

   input_debouncer #(.SYNC_STAGES(SS), .STABLE_CYCLES(ST), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .raw_in(raw_in), .enable(enable),
      .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edges++;

   // Reference: a new level is taken once the synchronized input has differed from it
   // for ST consecutive enabled edges; busy means such a run is in progress.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SS; i++) pipe[i] = 0;
         m_level = 0;
         run = 0;
         exp_q.delete();
      end else begin
         logic sq, r, f;
         sq = pipe[SS-1];
         r = 0;
         f = 0;
         if (!enable || sq == m_level) run = 0;
         else begin
            run++;
            if (run == ST) begin
               m_level = sq;
               r = sq;
               f = !sq;
               run = 0;
            end
         end
         for (int i = SS - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = raw_in;
         exp_q.push_back({m_level, r, f, run > 0});
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         #1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard t=%0t no expected entry", $time);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if ({level_out, rise_pulse, fall_pulse, busy} !== e) begin
               errors++;
               $display("FAIL scoreboard t=%0t got lvl/rise/fall/busy=%b exp %b", $time,
                        {level_out, rise_pulse, fall_pulse, busy}, e);
            end
         end
         rise_cnt += int'(rise_pulse);
         fall_cnt += int'(fall_pulse);
         if (busy) busy_seen = 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, act, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_level(input logic v, input int max, input int base, output int l);
      l = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (level_out === v) begin
            l = edges - base;
            break;
         end
      end
   endtask

   initial begin
      int e0, d;
      hold(3);
      reset = 0;
      chk("reset_level", int'(level_out), 0);
      chk("reset_busy", int'(busy), 0);
      hold(5);
      // glitch shorter than the stability window
      rise_cnt = 0;
      busy_seen = 0;
      raw_in = 1;
      hold(5);
      raw_in = 0;
      hold(25);
      chk("glitch_busy_seen", int'(busy_seen), 1);
      chk("glitch_level", int'(level_out), 0);
      chk("glitch_rise", rise_cnt, 0);
      chk("glitch_busy_end", int'(busy), 0);
      // clean rise
      raw_in = 1;
      e0 = edges + 1;
      wait_level(1, 40, e0, lat);
      chk("rise_latency", lat, SS + ST - 1);
      chk("rise_pulse_on", int'(rise_pulse), 1);
      hold(1);
      chk("rise_pulse_off", int'(rise_pulse), 0);
      hold(3);
      // clean fall
      rise_cnt = 0;
      fall_cnt = 0;
      raw_in = 0;
      e0 = edges + 1;
      wait_level(0, 40, e0, lat);
      chk("fall_latency", lat, SS + ST - 1);
      chk("fall_pulse_on", int'(fall_pulse), 1);
      hold(1);
      chk("fall_pulse_off", int'(fall_pulse), 0);
      chk("fall_no_rise", rise_cnt, 0);
      hold(3);
      // bounce then settle high
      rise_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         raw_in = 1;
         hold(3);
         raw_in = 0;
         hold(3);
      end
      raw_in = 1;
      e0 = edges + 1;
      wait_level(1, 40, e0, lat);
      chk("bounce_latency", lat, SS + ST - 1);
      hold(5);
      chk("bounce_rise_count", rise_cnt, 1);
      // asynchronous reset in the middle of a falling check
      raw_in = 0;
      hold(6);
      chk("pre_reset_busy", int'(busy), 1);
      #2 reset = 1;
      #1;
      chk("async_reset_level", int'(level_out), 0);
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_pulses", int'({rise_pulse, fall_pulse}), 0);
      hold(2);
      reset = 0;
      hold(4);
      // disable mid-check, then re-enable
      rise_cnt = 0;
      raw_in = 1;
      hold(10);
      chk("pre_disable_busy", int'(busy), 1);
      enable = 0;
      hold(1);
      chk("disable_busy", int'(busy), 0);
      chk("disable_level", int'(level_out), 0);
      d = edges;
      enable = 1;
      wait_level(1, 40, d, lat);
      chk("reenable_latency", lat, ST);
      chk("reenable_rise", int'(rise_pulse), 1);
      // randomized runs with occasional disable
      for (int i = 0; i < 250; i++) begin
         raw_in = 1'($urandom_range(1));
         enable = $urandom_range(9) != 0;
         hold($urandom_range(24, 1));
      end
      enable = 1;
      hold(30);
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
